// File: rtl/serial_pattern_tx_pkg.sv
// Shared definitions for the serial pattern transmitter: FSM state encoding
// (kept identical to the detector/receiver side of the link).
package serial_pattern_tx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2,
    ST_DONE  = 2'd3
  } tx_state_e;

  // Counter width able to hold 0..n, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n > 0) ? $clog2(n + 1) : 1;
  endfunction

endpackage

// File: rtl/load_down_counter.sv
// Loadable down counter with zero flag; load has priority over decrement.
module load_down_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] val_i,
  input  logic         dec_i,
  output logic [W-1:0] cnt_o,
  output logic         zero_o
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         cnt_q <= '0;
    else if (load_i) cnt_q <= val_i;
    else if (dec_i)  cnt_q <= cnt_q - W'(1);
  end

  assign cnt_o  = cnt_q;
  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/serial_pattern_tx.sv
// Serial bit-stream generator: shifts a captured pattern out MSB-first, one bit
// per clk, optionally repeated with an idle gap between repetitions.
module serial_pattern_tx
  import serial_pattern_tx_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int REP_W   = 4,
  parameter int GAP_CYC = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [WIDTH-1:0]           pattern,
  input  logic [$clog2(WIDTH+1)-1:0] len,
  input  logic [REP_W-1:0]           reps,
  output logic                       out,
  output logic                       out_valid,
  output logic                       ready,
  output logic                       busy,
  output logic                       done
);

  localparam int              LW      = $clog2(WIDTH + 1);
  localparam int              GW      = cnt_w(GAP_CYC);
  localparam bit              HAS_GAP = (GAP_CYC > 0);
  localparam logic [LW-1:0]   WIDTH_L = LW'(WIDTH);
  localparam logic [GW-1:0]   GAP_L   = GW'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);

  tx_state_e        state_q;
  logic [WIDTH-1:0] sh_q, pat_q;
  logic [LW-1:0]    len_q;
  logic [REP_W-1:0] rep_q;
  logic             out_q, vld_q, rdy_q, busy_q, done_q;

  logic [LW-1:0] len_c, bit_val_d, bit_cnt;
  logic [GW-1:0] gap_cnt;
  logic          accept, last_bit, reload;
  logic          bit_load_d, bit_dec_d, bit_zero;
  logic          gap_load_d, gap_dec_d, gap_zero;

  assign len_c    = (len > WIDTH_L) ? WIDTH_L : len;
  assign accept   = start && rdy_q;
  assign last_bit = (state_q == ST_SHIFT) && bit_zero;
  assign reload   = (last_bit && (rep_q != '0) && !HAS_GAP) ||
                    ((state_q == ST_GAP) && gap_zero);

  // Bit counter holds the number of bits still to come after the one on out.
  always_comb begin
    bit_load_d = (accept && (len_c != '0)) || reload;
    bit_val_d  = accept ? (len_c - LW'(1)) : (len_q - LW'(1));
    bit_dec_d  = (state_q == ST_SHIFT) && !bit_zero;
    gap_load_d = last_bit && (rep_q != '0) && HAS_GAP;
    gap_dec_d  = (state_q == ST_GAP) && !gap_zero;
  end

  load_down_counter #(.W(LW)) u_bit_cnt (
    .clk    (clk),
    .rst    (rst),
    .load_i (bit_load_d),
    .val_i  (bit_val_d),
    .dec_i  (bit_dec_d),
    .cnt_o  (bit_cnt),
    .zero_o (bit_zero)
  );

  load_down_counter #(.W(GW)) u_gap_cnt (
    .clk    (clk),
    .rst    (rst),
    .load_i (gap_load_d),
    .val_i  (GAP_L),
    .dec_i  (gap_dec_d),
    .cnt_o  (gap_cnt),
    .zero_o (gap_zero)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      sh_q    <= '0;
      pat_q   <= '0;
      len_q   <= '0;
      rep_q   <= '0;
      out_q   <= 1'b0;
      vld_q   <= 1'b0;
      rdy_q   <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: if (accept) begin
          pat_q  <= pattern;
          len_q  <= len_c;
          rep_q  <= reps;
          rdy_q  <= 1'b0;
          busy_q <= 1'b1;
          if (len_c != '0) begin
            state_q <= ST_SHIFT;
            out_q   <= pattern[WIDTH-1];
            sh_q    <= pattern << 1;
            vld_q   <= 1'b1;
          end else begin
            state_q <= ST_DONE;
            done_q  <= 1'b1;
          end
        end
        ST_SHIFT: begin
          if (!bit_zero) begin
            out_q <= sh_q[WIDTH-1];
            sh_q  <= sh_q << 1;
          end else if (rep_q != '0) begin
            rep_q <= rep_q - REP_W'(1);
            if (HAS_GAP) begin
              state_q <= ST_GAP;
              out_q   <= 1'b0;
              vld_q   <= 1'b0;
            end else begin
              out_q <= pat_q[WIDTH-1];
              sh_q  <= pat_q << 1;
            end
          end else begin
            state_q <= ST_DONE;
            out_q   <= 1'b0;
            vld_q   <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        ST_GAP: if (gap_zero) begin
          state_q <= ST_SHIFT;
          out_q   <= pat_q[WIDTH-1];
          sh_q    <= pat_q << 1;
          vld_q   <= 1'b1;
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          rdy_q   <= 1'b1;
          busy_q  <= 1'b0;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign out       = out_q;
  assign out_valid = vld_q;
  assign ready     = rdy_q;
  assign busy      = busy_q;
  assign done      = done_q;

  // Counter values are observed only through their zero flags.
  logic unused_cnt;
  assign unused_cnt = ^{bit_cnt, gap_cnt};

endmodule

// File: tb/tb_serial_pattern_tx.sv
// Directed, table-driven bench for serial_pattern_tx (GAP_CYC=1 and GAP_CYC=0 instances).
module tb_serial_pattern_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic       st1, st0;
  logic [7:0] pat;
  logic [3:0] len;
  logic [3:0] reps;
  logic       o1, v1, r1, b1, d1;
  logic       o0, v0, r0, b0, d0;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  serial_pattern_tx #(.WIDTH(8), .REP_W(4), .GAP_CYC(1)) dut_g1 (
    .clk(clk), .rst(rst), .start(st1), .pattern(pat), .len(len), .reps(reps),
    .out(o1), .out_valid(v1), .ready(r1), .busy(b1), .done(d1)
  );

  serial_pattern_tx #(.WIDTH(8), .REP_W(4), .GAP_CYC(0)) dut_g0 (
    .clk(clk), .rst(rst), .start(st0), .pattern(pat), .len(len), .reps(reps),
    .out(o0), .out_valid(v0), .ready(r0), .busy(b0), .done(d0)
  );

  typedef struct {
    string       name;
    logic        gap0;     // 1: drive the GAP_CYC=0 instance
    logic        hold;     // keep start high for the whole transfer
    logic [7:0]  pat;
    logic [3:0]  len;
    logic [3:0]  reps;
    int          done_cyc; // cycle after accept carrying the done pulse
    logic [31:0] vmask;    // bit k-1 = expected out_valid in cycle k
    logic [31:0] omask;    // bit k-1 = expected out in cycle k
  } vec_t;

  vec_t vecs[8];

  // {out_valid, out, done, ready, busy}
  function automatic logic [4:0] snap(input logic g0);
    return g0 ? {v0, o0, d0, r0, b0} : {v1, o1, d1, r1, b1};
  endfunction

  task automatic chk(input string nm, input int k, input logic [4:0] got, input logic [4:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s cyc%0d v/o/d/r/b got=%b want=%b", nm, k, got, exp);
  endtask

  task automatic wait_ready(input logic g0, input string nm);
    bit ok = 0;
    for (int i = 0; i < 60 && !ok; i++) begin
      if ((g0 ? r0 : r1) === 1'b1) ok = 1;
      else @(negedge clk);
    end
    if (!ok) begin
      total++;
      $display("FAIL %s ready timeout got=0 want=1", nm);
    end
  endtask

  task automatic run_vec(input vec_t v);
    logic [4:0] exp;
    wait_ready(v.gap0, v.name);
    pat = v.pat; len = v.len; reps = v.reps;
    if (v.gap0) st0 = 1'b1; else st1 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    if (!v.hold) begin
      st0 = 1'b0; st1 = 1'b0;
      pat = ~v.pat; len = 4'd3; reps = 4'd15;  // must not disturb the transfer
    end
    for (int k = 1; k <= v.done_cyc + 1; k++) begin
      exp = {v.vmask[k-1], v.omask[k-1], (k == v.done_cyc),
             (k > v.done_cyc), (k <= v.done_cyc)};
      chk(v.name, k, snap(v.gap0), exp);
      if (k <= v.done_cyc) @(negedge clk);
    end
    if (v.hold) begin
      // start still high in the first IDLE cycle: a new transfer begins
      @(posedge clk);
      @(negedge clk);
      chk({v.name, "_restart"}, 1, snap(v.gap0) & 5'b11000, {1'b1, v.pat[7], 3'b000});
      st0 = 1'b0; st1 = 1'b0;
      @(negedge clk);
      wait_ready(v.gap0, v.name);
    end
  endtask

  initial begin
    vecs[0] = '{"t1_basic",   1'b0, 1'b0, 8'hB2, 4'd8,  4'd0, 9,  32'h0FF, 32'h04D};
    vecs[1] = '{"t2_reps",    1'b0, 1'b0, 8'hC0, 4'd3,  4'd2, 12, 32'h777, 32'h333};
    vecs[2] = '{"t3_nogap",   1'b1, 1'b0, 8'hA0, 4'd2,  4'd1, 5,  32'h00F, 32'h005};
    vecs[3] = '{"t4_len0",    1'b0, 1'b0, 8'hFF, 4'd0,  4'd3, 1,  32'h000, 32'h000};
    vecs[4] = '{"t4_clamp",   1'b0, 1'b0, 8'hB2, 4'd12, 4'd0, 9,  32'h0FF, 32'h04D};
    vecs[5] = '{"len1_rep1",  1'b0, 1'b0, 8'h80, 4'd1,  4'd1, 4,  32'h005, 32'h005};
    vecs[6] = '{"nogap_5a",   1'b1, 1'b0, 8'h5A, 4'd4,  4'd0, 5,  32'h00F, 32'h00A};
    vecs[7] = '{"t5_hold",    1'b0, 1'b1, 8'hB2, 4'd8,  4'd0, 9,  32'h0FF, 32'h04D};

    rst = 1'b1; st1 = 1'b0; st0 = 1'b0; pat = '0; len = '0; reps = '0;
    @(negedge clk);
    @(negedge clk);
    chk("reset_g1", 0, snap(1'b0), 5'b00010);
    chk("reset_g0", 0, snap(1'b1), 5'b00010);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 8; i++) run_vec(vecs[i]);

    // Asynchronous reset in the middle of a shift, then a fresh full transfer.
    wait_ready(1'b0, "t6_pre");
    pat = 8'hB2; len = 4'd8; reps = 4'd0; st1 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    st1 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("t6_bit3", 3, snap(1'b0), 5'b11001);
    #2 rst = 1'b1;
    #1 chk("t6_async_rst", 0, snap(1'b0), 5'b00010);
    #3 rst = 1'b0;
    @(negedge clk);
    run_vec(vecs[0]);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
